// File: rtl/combinational_multiplier_if.sv
// Operand/result bundle for the unsigned array multiplier.
// The master drives operands; the slave returns combinational and registered products.
interface combinational_multiplier_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               in_valid;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] product_q;
  logic               out_valid;

  modport master (
    output A, B, in_valid,
    input  product, product_q, out_valid
  );

  modport slave (
    input  A, B, in_valid,
    output product, product_q, out_valid
  );
endinterface

// File: rtl/combinational_multiplier.sv
// Unsigned WIDTH x WIDTH array multiplier built from an AND matrix and ripple
// rows of full adders, with a single registered copy of the product.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module combinational_multiplier #(
  parameter int WIDTH = 4
) (
  input logic                        clk,
  input logic                        rst_n,
  combinational_multiplier_if.slave  bus
);
  localparam int PW = 2 * WIDTH;

  logic [WIDTH-1:0] pp      [WIDTH];
  logic [WIDTH-1:0] run_s   [WIDTH];
  logic [WIDTH-1:0] sum_row [1:WIDTH-1];
  logic [WIDTH:0]   carry   [1:WIDTH-1];
  logic [PW-1:0]    prod_s;
  logic [PW-1:0]    product_q_r;
  logic             out_valid_r;

  genvar i, j;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_pp_row
      for (j = 0; j < WIDTH; j++) begin : g_pp_bit
        assign pp[i][j] = bus.A[j] & bus.B[i];
      end
    end

    // run_s[i] carries the not-yet-retired upper bits of the running sum.
    assign prod_s[0] = pp[0][0];
    assign run_s[0]  = {1'b0, pp[0][WIDTH-1:1]};

    for (i = 1; i < WIDTH; i++) begin : g_row
      assign carry[i][0] = 1'b0;
      for (j = 0; j < WIDTH; j++) begin : g_fa
        full_adder u_fa (
          .a    (pp[i][j]),
          .b    (run_s[i-1][j]),
          .cin  (carry[i][j]),
          .sum  (sum_row[i][j]),
          .cout (carry[i][j+1])
        );
      end
      assign prod_s[i] = sum_row[i][0];
      assign run_s[i]  = {carry[i][WIDTH], sum_row[i][WIDTH-1:1]};
    end
  endgenerate

  assign prod_s[PW-1:WIDTH] = run_s[WIDTH-1];
  assign bus.product        = prod_s;

  // Output register: captures the product only on qualified cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product_q_r <= {PW{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= bus.in_valid;
      if (bus.in_valid) begin
        product_q_r <= prod_s;
      end else begin
        product_q_r <= product_q_r;
      end
    end
  end

  assign bus.product_q = product_q_r;
  assign bus.out_valid = out_valid_r;
endmodule

// File: tb/tb_combinational_multiplier.sv
// Self-checking bench for combinational_multiplier: directed corners, exhaustive
// sweep and randomized streams against an arithmetic reference model.
module tb_combinational_multiplier;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  combinational_multiplier_if #(.WIDTH(4)) bus ();

  combinational_multiplier #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_mul(input int a, input int b);
    return 8'(a * b);
  endfunction

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    #2;
    chk("reset_product", bus.product, 8'h00);
    chk("reset_product_q", bus.product_q, 8'h00);
    chk("reset_out_valid", {7'd0, bus.out_valid}, 8'h00);
  endtask

  task automatic test_comb_under_reset();
    int a;
    int b;
    bus.A = 4'b1010; bus.B = 4'b0011;
    #1;
    chk("comb_10x3", bus.product, 8'h1E);
    bus.A = 4'hF; bus.B = 4'hF;
    #1;
    chk("comb_15x15", bus.product, 8'hE1);
    chk("comb_top_carry", {7'd0, bus.product[7]}, 8'h01);
    for (int k = 0; k < 8; k++) begin
      a = $urandom_range(15, 0);
      b = $urandom_range(15, 0);
      bus.A = 4'(a); bus.B = 4'(b);
      #1;
      chk("comb_rand_in_reset", bus.product, ref_mul(a, b));
    end
    chk("reset_hold_product_q", bus.product_q, 8'h00);
  endtask

  task automatic test_registered();
    @(negedge clk);
    rst_n = 1'b1;
    bus.A = 4'd7; bus.B = 4'd9; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    chk("reg_product_q_63", bus.product_q, 8'd63);
    chk("reg_out_valid_1", {7'd0, bus.out_valid}, 8'h01);
    @(negedge clk);
    bus.in_valid = 1'b0; bus.A = 4'd3; bus.B = 4'd3;
    @(posedge clk); #1;
    chk("reg_out_valid_0", {7'd0, bus.out_valid}, 8'h00);
    chk("reg_hold_63", bus.product_q, 8'd63);
  endtask

  task automatic test_mid_reset();
    int a;
    int b;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.A = 4'd5; bus.B = 4'd6;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_product_q", bus.product_q, 8'h00);
    chk("midrst_out_valid", {7'd0, bus.out_valid}, 8'h00);
    a = $urandom_range(15, 0);
    b = $urandom_range(15, 0);
    bus.A = 4'(a); bus.B = 4'(b);
    #1;
    chk("midrst_product_tracks", bus.product, ref_mul(a, b));
    @(posedge clk); #1;
    chk("midrst_dropped_q", bus.product_q, 8'h00);
    chk("midrst_dropped_valid", {7'd0, bus.out_valid}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1; bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("release_idle_valid", {7'd0, bus.out_valid}, 8'h00);
    chk("release_idle_q", bus.product_q, 8'h00);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.A = 4'd12; bus.B = 4'd11;
    @(posedge clk); #1;
    chk("release_first_valid", {7'd0, bus.out_valid}, 8'h01);
    chk("release_first_q", bus.product_q, 8'd132);
  endtask

  task automatic test_sweep();
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        @(negedge clk);
        bus.A = 4'(a); bus.B = 4'(b); bus.in_valid = 1'b1;
        #1;
        chk("sweep_comb", bus.product, ref_mul(a, b));
        @(posedge clk); #1;
        chk("sweep_reg", bus.product_q, ref_mul(a, b));
        chk("sweep_valid", {7'd0, bus.out_valid}, 8'h01);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q;
    logic       exp_v;
    int a;
    int b;
    logic v;
    exp_q = bus.product_q;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      a = $urandom_range(15, 0);
      b = $urandom_range(15, 0);
      v = 1'($urandom_range(1, 0));
      bus.A = 4'(a); bus.B = 4'(b); bus.in_valid = v;
      if (v) exp_q = ref_mul(a, b);
      exp_v = v;
      @(posedge clk); #1;
      chk("b2b_q", bus.product_q, exp_q);
      chk("b2b_valid", {7'd0, bus.out_valid}, {7'd0, exp_v});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.A = 4'd0; bus.B = 4'd0; bus.in_valid = 1'b0;
    test_reset();
    test_comb_under_reset();
    test_registered();
    test_mid_reset();
    test_sweep();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
